change_dispenser: RTL and testbench

- Payout end of the vending machine's change/refund interface.
- Receives a unit amount from the vending controller (change after a sale, or the full refund after cancel).
- Pays the amount out as physical coins: 2-unit coins first, then 1-unit coins.
- Drives a coin ejector mechanism with a strobe/acknowledge handshake, tracks per-denomination hopper inventory, and reports any unpaid shortfall.

---
 rtl/vm_pkg.sv | 18 +
 rtl/coin_hopper.sv | 37 +++
 rtl/change_dispenser.sv | 140 ++++++++++++++
 tb/tb_change_dispenser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine change/refund path.
package vm_pkg;

   localparam int AMT_W_DEF = 3;

   localparam int COIN1 = 1;
   localparam int COIN2 = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PLAN     = 3'd1,
      ST_EJECT    = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

endpackage

// File: rtl/coin_hopper.sv
// Inventory counter for one coin denomination; reloads to INIT on reset or load.
module coin_hopper #(
   parameter int INV_W = 6,
   parameter int INIT  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   output logic [INV_W-1:0] count,
   output logic             empty
);

   logic [INV_W-1:0] count_q;
   logic [INV_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = INV_W'(INIT);
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - INV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= INV_W'(INIT);
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays a requested amount out as coins (2-unit first, then 1-unit) through a
// strobe/ack ejector, tracking hopper inventory and any unpaid shortfall.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request; refill honoured here only
// PLAN     | pick next coin from rem and inventory, or finish
// EJECT    | one-cycle strobe for the chosen coin
// WAIT_ACK | wait for ejector ack; timer guards against a stuck ejector
// DONE     | one-cycle done pulse, short_amt holds rem
// FAULT    | ejector timed out; only reset leaves
module change_dispenser
   import vm_pkg::*;
#(
   parameter int AMT_W         = AMT_W_DEF,
   parameter int INV_W         = 6,
   parameter int INIT_INV1     = 16,
   parameter int INIT_INV2     = 16,
   parameter int EJECT_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [AMT_W-1:0] amt,
   output logic             ready,
   output logic             ej1,
   output logic             ej2,
   input  logic             ej_ack,
   input  logic             refill,
   output logic             done,
   output logic [AMT_W-1:0] short_amt,
   output logic             fault,
   output logic [INV_W-1:0] inv1,
   output logic [INV_W-1:0] inv2
);

   localparam int TMR_W = $clog2(EJECT_TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [AMT_W-1:0]   rem_q, rem_d;
   logic [AMT_W-1:0]   short_q, short_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               coin2_q, coin2_d;
   logic               empty1, empty2;
   logic               load_inv, ack_ok;

   assign load_inv = (state_q == ST_IDLE) && refill;
   assign ack_ok   = (state_q == ST_WAIT_ACK) && ej_ack;

   coin_hopper #(.INV_W(INV_W), .INIT(INIT_INV1)) u_hopper1 (
      .clk   (clk),
      .rst   (rst),
      .load  (load_inv),
      .dec   (ack_ok && !coin2_q),
      .count (inv1),
      .empty (empty1)
   );

   coin_hopper #(.INV_W(INV_W), .INIT(INIT_INV2)) u_hopper2 (
      .clk   (clk),
      .rst   (rst),
      .load  (load_inv),
      .dec   (ack_ok && coin2_q),
      .count (inv2),
      .empty (empty2)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      short_d = short_q;
      timer_d = timer_q;
      coin2_d = coin2_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req && !refill) begin
               rem_d   = amt;
               state_d = ST_PLAN;
            end
         end
         ST_PLAN: begin
            // short_amt is captured here so it is already valid during DONE
            if (rem_q == '0) begin
               short_d = rem_q;
               state_d = ST_DONE;
            end else if ((rem_q >= AMT_W'(COIN2)) && !empty2) begin
               coin2_d = 1'b1;
               state_d = ST_EJECT;
            end else if (!empty1) begin
               coin2_d = 1'b0;
               state_d = ST_EJECT;
            end else begin
               short_d = rem_q;
               state_d = ST_DONE;
            end
         end
         ST_EJECT: begin
            timer_d = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ej_ack) begin
               rem_d   = rem_q - (coin2_q ? AMT_W'(COIN2) : AMT_W'(COIN1));
               state_d = ST_PLAN;
            end else if (timer_q == TMR_W'(EJECT_TIMEOUT)) begin
               state_d = ST_FAULT;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         short_q <= '0;
         timer_q <= '0;
         coin2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         short_q <= short_d;
         timer_q <= timer_d;
         coin2_q <= coin2_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign ej1       = (state_q == ST_EJECT) && !coin2_q;
   assign ej2       = (state_q == ST_EJECT) && coin2_q;
   assign done      = (state_q == ST_DONE);
   assign fault     = (state_q == ST_FAULT);
   assign short_amt = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (16/16 and 1/1 hoppers), a greedy
// payout model feeding an event scoreboard, and an auto-acking ejector.
module tb_change_dispenser;

   logic       clk, rst, req, refill, ej_ack, ack_man, sel;
   logic [2:0] amt;

   logic       a_ready, a_ej1, a_ej2, a_done, a_fault;
   logic [2:0] a_short;
   logic [5:0] a_inv1, a_inv2;
   logic       b_ready, b_ej1, b_ej2, b_done, b_fault;
   logic [2:0] b_short;
   logic [5:0] b_inv1, b_inv2;

   logic       m_ready, m_ej1, m_ej2, m_done, m_fault;
   logic [2:0] m_short;
   logic [5:0] m_inv1, m_inv2;

   change_dispenser #(.AMT_W(3), .INV_W(6), .INIT_INV1(16), .INIT_INV2(16), .EJECT_TIMEOUT(15)) u_dut_a (
      .clk(clk), .rst(rst), .req(req & ~sel), .amt(amt), .ready(a_ready),
      .ej1(a_ej1), .ej2(a_ej2), .ej_ack((ej_ack | ack_man) & ~sel), .refill(refill & ~sel),
      .done(a_done), .short_amt(a_short), .fault(a_fault), .inv1(a_inv1), .inv2(a_inv2));

   change_dispenser #(.AMT_W(3), .INV_W(6), .INIT_INV1(1), .INIT_INV2(1), .EJECT_TIMEOUT(15)) u_dut_b (
      .clk(clk), .rst(rst), .req(req & sel), .amt(amt), .ready(b_ready),
      .ej1(b_ej1), .ej2(b_ej2), .ej_ack((ej_ack | ack_man) & sel), .refill(refill & sel),
      .done(b_done), .short_amt(b_short), .fault(b_fault), .inv1(b_inv1), .inv2(b_inv2));

   assign m_ready = sel ? b_ready : a_ready;
   assign m_ej1   = sel ? b_ej1   : a_ej1;
   assign m_ej2   = sel ? b_ej2   : a_ej2;
   assign m_done  = sel ? b_done  : a_done;
   assign m_fault = sel ? b_fault : a_fault;
   assign m_short = sel ? b_short : a_short;
   assign m_inv1  = sel ? b_inv1  : a_inv1;
   assign m_inv2  = sel ? b_inv2  : a_inv2;

   typedef struct {
      int kind;   // 1 = ej1, 2 = ej2, 3 = done
      int val;    // short_amt for done
   } ev_t;

   typedef struct {
      bit       s;
      int       a;
      int       dly;
      int       exp_short;
      int       exp_inv1;
      int       exp_inv2;
   } vec_t;

   ev_t  expq[$];
   vec_t vecs[14];

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc, last_ack, ack_at, ack_dly;
   bit ack_en, done_seen;
   int m_inv1_mdl[2];
   int m_inv2_mdl[2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic push_ev(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      expq.push_back(e);
   endtask

   // Greedy payout model: 2-unit coins while possible, then 1-unit coins.
   task automatic plan(input bit s, input int a);
      int rem;
      rem = a;
      while (rem > 0) begin
         if (rem >= 2 && m_inv2_mdl[s] > 0) begin
            push_ev(2, 0); m_inv2_mdl[s]--; rem -= 2;
         end else if (m_inv1_mdl[s] > 0) begin
            push_ev(1, 0); m_inv1_mdl[s]--; rem -= 1;
         end else begin
            break;
         end
      end
      push_ev(3, rem);
   endtask

   // Ejector responder and scoreboard monitor.
   always @(negedge clk) begin
      int  kind, due;
      ev_t e;
      ej_ack = 1'b0;
      if (!rst) begin
         if (ack_en && ack_at == cyc) begin
            ej_ack   = 1'b1;
            last_ack = cyc;
            ack_at   = -1;
         end
         if (m_ej1 || m_ej2 || m_done) begin
            if (m_ej1 && m_ej2) chk("both_strobes", 1, 0);
            kind = m_done ? 3 : (m_ej2 ? 2 : 1);
            due  = (last_ack >= 0) ? last_ack + 2 : acc + 2;
            chk("event_cycle", cyc, due);
            if (expq.size() == 0) begin
               chk("unexpected_event", kind, 0);
            end else begin
               e = expq.pop_front();
               chk("event_kind", kind, e.kind);
               if (kind == 3) chk("done_short", m_short, e.val);
            end
            if (kind == 3) done_seen = 1'b1;
            else if (ack_en) ack_at = cyc + ack_dly;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 1'b0; refill = 1'b0; ack_man = 1'b0; ack_en = 1'b0;
      expq.delete();
      ack_at = -1; last_ack = -1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_inv1_mdl[0] = 16; m_inv2_mdl[0] = 16;
      m_inv1_mdl[1] = 1;  m_inv2_mdl[1] = 1;
   endtask

   task automatic accept_and_wait(input int a);
      int n;
      @(negedge clk);
      req = 1'b1; amt = 3'(a); n = 0;
      while (!m_ready && n < 20) begin @(negedge clk); n++; end
      acc = cyc; last_ack = -1;
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!done_seen && n < 400) begin @(negedge clk); n++; end
      chk("done_seen", done_seen, 1);
   endtask

   task automatic pay(input bit s, input int a, input int dly);
      sel = s; ack_dly = dly; ack_en = 1'b1; done_seen = 1'b0;
      plan(s, a);
      accept_and_wait(a);
   endtask

   initial begin
      int n;
      vecs[0]  = '{0, 3, 2, 0, 15, 15};
      vecs[1]  = '{0, 0, 2, 0, 15, 15};
      vecs[2]  = '{0, 7, 1, 0, 14, 12};
      vecs[3]  = '{0, 7, 3, 0, 13, 9};
      vecs[4]  = '{0, 7, 1, 0, 12, 6};
      vecs[5]  = '{0, 7, 2, 0, 11, 3};
      vecs[6]  = '{0, 7, 1, 0, 10, 0};
      vecs[7]  = '{0, 5, 1, 0, 5, 0};
      vecs[8]  = '{0, 2, 2, 0, 3, 0};
      vecs[9]  = '{0, 3, 1, 0, 0, 0};
      vecs[10] = '{0, 7, 1, 7, 0, 0};
      vecs[11] = '{1, 3, 1, 0, 0, 0};
      vecs[12] = '{1, 2, 3, 2, 0, 0};
      vecs[13] = '{1, 1, 1, 1, 0, 0};

      sel = 1'b0; amt = '0; ack_dly = 1; acc = 0; done_seen = 1'b0;
      do_reset();

      chk("rst_ready",  a_ready, 1);
      chk("rst_fault",  a_fault, 0);
      chk("rst_done",   a_done,  0);
      chk("rst_strobe", {a_ej1, a_ej2}, 0);
      chk("rst_short",  a_short, 0);
      chk("rst_inv1_a", a_inv1, 16);
      chk("rst_inv2_a", a_inv2, 16);
      chk("rst_inv1_b", b_inv1, 1);
      chk("rst_inv2_b", b_inv2, 1);

      foreach (vecs[i]) begin
         pay(vecs[i].s, vecs[i].a, vecs[i].dly);
         @(negedge clk);
         chk($sformatf("v%0d_short", i), m_short, vecs[i].exp_short);
         chk($sformatf("v%0d_inv1", i),  m_inv1,  vecs[i].exp_inv1);
         chk($sformatf("v%0d_inv2", i),  m_inv2,  vecs[i].exp_inv2);
         chk($sformatf("v%0d_ready", i), m_ready, 1);
         chk($sformatf("v%0d_queue", i), expq.size(), 0);
      end

      // Refill and request together in IDLE: reload wins, request taken next cycle.
      sel = 1'b0; ack_dly = 1; ack_en = 1'b1; done_seen = 1'b0;
      m_inv1_mdl[0] = 16; m_inv2_mdl[0] = 16;
      plan(0, 5);
      @(negedge clk);
      req = 1'b1; amt = 3'd5; refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      chk("refill_inv1", a_inv1, 16);
      chk("refill_inv2", a_inv2, 16);
      chk("refill_no_accept", a_ready, 1);
      acc = cyc; last_ack = -1;
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!done_seen && n < 400) begin @(negedge clk); n++; end
      chk("refill_done_seen", done_seen, 1);
      @(negedge clk);
      chk("refill_pay_inv1", a_inv1, 15);
      chk("refill_pay_inv2", a_inv2, 14);

      // Ejector never acks: fault exactly after the timeout, sticky, ack ignored.
      sel = 1'b0; ack_en = 1'b0; done_seen = 1'b0;
      push_ev(1, 0);
      @(negedge clk);
      req = 1'b1; amt = 3'd1;
      acc = cyc; last_ack = -1;
      @(negedge clk);
      req = 1'b0;
      while (cyc < acc + 18) @(negedge clk);
      chk("fault_early", a_fault, 0);
      @(negedge clk);
      chk("fault_set", a_fault, 1);
      chk("fault_ready", a_ready, 0);
      ack_man = 1'b1; req = 1'b1; refill = 1'b1;
      repeat (3) @(negedge clk);
      ack_man = 1'b0; req = 1'b0; refill = 1'b0;
      @(negedge clk);
      chk("fault_sticky", a_fault, 1);
      chk("fault_inv1", a_inv1, 15);
      chk("fault_inv2", a_inv2, 14);
      chk("fault_no_done", done_seen, 0);

      do_reset();
      @(negedge clk);
      chk("rst2_fault", a_fault, 0);
      chk("rst2_ready", a_ready, 1);
      chk("rst2_inv1",  a_inv1, 16);
      chk("rst2_inv2",  a_inv2, 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
